// File: rtl/nrzi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nrzi_pkg
// Brief    : Shared constants for the NRZI serial link (receiver and transmitter)
// Revision : 1.0  initial release
// ============================================================================
package nrzi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t HUNT = 2'd1;
  localparam state_t DATA = 2'd2;

  localparam logic [7:0] SYNC_DEFAULT      = 8'hA5;
  localparam int         STUFF_RUN_DEFAULT = 6;

endpackage
`default_nettype wire

// File: rtl/nrzi_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module   : nrzi_bit_decoder
// Brief    : NRZI decode (toggle = 1) plus run-of-ones tracking for destuffing
// Revision : 1.0  initial release
// ============================================================================
module nrzi_bit_decoder
  import nrzi_pkg::*;
#(
  parameter int STUFF_RUN = STUFF_RUN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  input  logic bit_en,
  input  logic in_data,
  input  logic ones_clr,
  output logic dec_bit,
  output logic dec_strobe,
  output logic stuff_drop,
  output logic stuff_err
);

  logic       r_prev_line;
  logic [2:0] r_ones;
  logic       w_at_run;

  assign dec_bit    = line_in ^ r_prev_line;
  assign dec_strobe = bit_en;
  assign w_at_run   = (r_ones == 3'(STUFF_RUN));
  // Once the run limit is reached the next bit must be the stuffed 0.
  assign stuff_drop = bit_en & in_data & w_at_run & ~dec_bit;
  assign stuff_err  = bit_en & in_data & w_at_run &  dec_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_line <= 1'b0;
      r_ones      <= 3'd0;
    end else begin
      if (bit_en) begin
        r_prev_line <= line_in;
      end
      if (ones_clr) begin
        r_ones <= 3'd0;
      end else if (bit_en && in_data) begin
        if (w_at_run || !dec_bit) begin
          r_ones <= 3'd0;
        end else begin
          r_ones <= r_ones + 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nrzi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : nrzi_frame_rx
// Brief    : NRZI frame receiver: sync hunt, destuffing, byte assembly, 1-entry slot
// Revision : 1.0  initial release
// ============================================================================
module nrzi_frame_rx
  import nrzi_pkg::*;
#(
  parameter logic [7:0] SYNC        = SYNC_DEFAULT,
  parameter int         FRAME_BYTES = 4,
  parameter int         STUFF_RUN   = STUFF_RUN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_in,
  input  logic       bit_en,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       data_last,
  output logic       frame_err,
  output logic       overflow
);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_shreg;
  logic [2:0] r_bitcnt;
  logic [7:0] r_bytecnt;

  logic       w_dec_bit;
  logic       w_dec_strobe;
  logic       w_stuff_drop;
  logic       w_stuff_err;
  logic [7:0] w_new_shreg;
  logic       w_sync_hit;
  logic       w_shift;
  logic       w_byte_done;
  logic       w_last;
  logic       w_load;

  nrzi_bit_decoder #(
    .STUFF_RUN (STUFF_RUN)
  ) u_dec (
    .clk        (clk),
    .rst        (rst),
    .line_in    (line_in),
    .bit_en     (bit_en),
    .in_data    (r_state == DATA),
    .ones_clr   (w_sync_hit),
    .dec_bit    (w_dec_bit),
    .dec_strobe (w_dec_strobe),
    .stuff_drop (w_stuff_drop),
    .stuff_err  (w_stuff_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_dec_strobe) w_next_state = HUNT;
      HUNT:    if (w_sync_hit) w_next_state = DATA;
      DATA:    if (w_stuff_err || w_last) w_next_state = HUNT;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_new_shreg = {w_dec_bit, r_shreg[7:1]};
    w_sync_hit  = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      HUNT:    w_sync_hit = w_dec_strobe && (w_new_shreg == SYNC);
      DATA:    w_shift    = w_dec_strobe && !w_stuff_drop && !w_stuff_err;
      default: ;
    endcase
    w_byte_done = w_shift && (r_bitcnt == 3'd7);
    w_last      = w_byte_done && (r_bytecnt == 8'(FRAME_BYTES - 1));
    // Same-cycle accept frees the slot for the completing byte.
    w_load      = w_byte_done && (!data_valid || data_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg    <= 8'd0;
      r_bitcnt   <= 3'd0;
      r_bytecnt  <= 8'd0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (r_state == HUNT && w_dec_strobe) begin
        r_shreg <= w_new_shreg;
      end else if (r_state == DATA) begin
        // Leaving DATA wipes the shifter so payload bits can't form a sync.
        if (w_stuff_err || w_last) begin
          r_shreg <= 8'd0;
        end else if (w_shift) begin
          r_shreg <= w_new_shreg;
        end
      end

      if (w_sync_hit) begin
        r_bitcnt  <= 3'd0;
        r_bytecnt <= 8'd0;
      end else begin
        if (w_shift) r_bitcnt <= r_bitcnt + 3'd1;
        if (w_byte_done) r_bytecnt <= r_bytecnt + 8'd1;
      end

      if (w_load) begin
        data_out   <= w_new_shreg;
        data_last  <= w_last;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      frame_err <= w_stuff_err;
      overflow  <= w_byte_done && data_valid && !data_ready;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nrzi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_nrzi_frame_rx
// Brief    : Bench for nrzi_frame_rx driven from a reference NRZI/stuffing encoder
// Revision : 1.0  initial release
// ============================================================================
module tb_nrzi_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line_in = 1'b0;
  logic       bit_en = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_last;
  logic       frame_err;
  logic       overflow;

  nrzi_frame_rx dut (
    .clk        (clk),
    .rst        (rst),
    .line_in    (line_in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_last  (data_last),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [8:0] cap_q[$];
  int         ovf_cnt  = 0;
  int         ferr_cnt = 0;
  logic [7:0] pl[$];
  logic       tx_lv[$];
  logic       tx_done[$];
  logic       lvl      = 1'b0;
  int         rdy_mode = 1;
  int         duty     = 100;
  logic [7:0] sync_b   = 8'hA5;

  always @(negedge clk) begin
    if (rst) begin
      if (data_valid && data_ready) cap_q.push_back({data_last, data_out});
      if (overflow) ovf_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level toggles for a decoded 1.
  task automatic push_bit(input logic b, input logic done);
    if (b) lvl = ~lvl;
    tx_lv.push_back(lvl);
    tx_done.push_back(done);
  endtask

  task automatic enc_head();
    for (int i = 0; i < 4; i++) push_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) push_bit(sync_b[i], 1'b0);
  endtask

  task automatic enc_payload();
    int ones = 0;
    for (int k = 0; k < pl.size(); k++) begin
      logic [7:0] b = pl[k];
      for (int i = 0; i < 8; i++) begin
        push_bit(b[i], i == 7);
        ones = b[i] ? ones + 1 : 0;
        if (ones == 6 && !(k == pl.size() - 1 && i == 7)) begin
          push_bit(1'b0, 1'b0);
          ones = 0;
        end
      end
    end
  endtask

  task automatic clear();
    cap_q.delete();
    tx_lv.delete();
    tx_done.delete();
    ovf_cnt  = 0;
    ferr_cnt = 0;
  endtask

  task automatic drive_bit(input logic lv, input logic flag);
    while (duty < 100 && $urandom_range(99, 0) >= duty) begin
      bit_en     = 1'b0;
      data_ready = (rdy_mode == 1);
      @(posedge clk); #1;
    end
    line_in    = lv;
    bit_en     = 1'b1;
    data_ready = (rdy_mode == 1) || (rdy_mode == 2 && flag);
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) drive_bit(tx_lv[i], tx_done[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bit_en     = 1'b0;
      data_ready = (rdy_mode == 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, cap_q.size(), pl.size());
    for (int i = 0; i < cap_q.size() && i < pl.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), int'(cap_q[i]),
          int'({(i == pl.size() - 1) ? 1'b1 : 1'b0, pl[i]}));
  endtask

  task automatic rand_payload();
    pl.delete();
    for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_last", int'(data_last), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b1;
    idle(2);

    // basic frame
    clear(); pl = '{8'h3C, 8'h00, 8'h81, 8'h7E}; rdy_mode = 1;
    enc_head(); enc_payload(); send(tx_lv.size()); idle(4);
    check_frame("t1");
    chk("t1_ferr", ferr_cnt, 0);
    chk("t1_ovf", ovf_cnt, 0);

    // stuffing on long runs of ones
    clear(); pl = '{8'hFF, 8'hFF, 8'h01, 8'h02};
    enc_head(); enc_payload(); send(tx_lv.size()); idle(4);
    check_frame("t2");
    chk("t2_ferr", ferr_cnt, 0);

    // seven ones after sync with no stuffed zero
    clear(); enc_head();
    for (int i = 0; i < 7; i++) push_bit(1'b1, 1'b0);
    send(tx_lv.size()); idle(3);
    chk("t3_ferr", ferr_cnt, 1);
    chk("t3_nodata", cap_q.size(), 0);
    clear(); rand_payload();
    enc_head(); enc_payload(); send(tx_lv.size()); idle(4);
    check_frame("t3_after");

    // consumer stalled for the whole frame
    clear(); pl = '{8'h11, 8'h22, 8'h33, 8'h44}; rdy_mode = 0;
    enc_head(); enc_payload(); send(tx_lv.size()); idle(3);
    chk("t4_valid", int'(data_valid), 1);
    chk("t4_data", int'(data_out), 'h11);
    chk("t4_last", int'(data_last), 0);
    chk("t4_ovf", ovf_cnt, 3);
    chk("t4_noxfer", cap_q.size(), 0);
    rdy_mode = 1; idle(3);
    chk("t4_count", cap_q.size(), 1);
    if (cap_q.size() > 0) chk("t4_byte", int'(cap_q[0]), 'h011);

    // ready only in byte-complete cycles: accept and load together
    clear(); rand_payload(); rdy_mode = 2;
    enc_head(); enc_payload(); send(tx_lv.size());
    rdy_mode = 1; idle(4);
    check_frame("t5");
    chk("t5_ovf", ovf_cnt, 0);

    // sparse bit_en with a reset mid-frame
    clear(); rand_payload(); rdy_mode = 0; duty = $urandom_range(60, 20);
    enc_head(); enc_payload(); send(tx_lv.size() - 6);
    chk("t6_held", int'(data_valid), 1);
    rst = 1'b0; #1;
    chk("t6_rst_valid", int'(data_valid), 0);
    chk("t6_rst_data", int'(data_out), 0);
    chk("t6_rst_pulses", int'(frame_err | overflow | data_last), 0);
    @(posedge clk); #1;
    idle(2);
    rst = 1'b1;
    clear(); rand_payload(); rdy_mode = 1;
    enc_head(); enc_payload(); send(tx_lv.size()); idle(4);
    check_frame("t6");
    chk("t6_ferr", ferr_cnt, 0);
    chk("t6_ovf", ovf_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
